// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
//   Bundles the decoder/issue, writeback-broadcast, register-file query and
//   commit signals of the reorder buffer.
//
//   Handshake semantics:
//     issue  : an entry is allocated on a posedge where issue_valid && issue_ready.
//              issue_tag names the entry that would be allocated.
//     wb     : wb_valid is a one-cycle strobe with no back-pressure.
//     commit : commit is a one-cycle retire strobe with no back-pressure.
//              The register file must take commit_rd/commit_data/commit_tag
//              in the cycle that commit is high.
//     pause  : freezes every state update. Producers hold their inputs while
//              pause is high.
//
//   Modports:
//     master : decoder / execution units / register file side (drives requests)
//     slave  : reorder buffer side
// -----------------------------------------------------------------------------
interface reorder_buffer_if #(
  parameter int XLEN = 32
);
  logic            pause;
  logic            flush;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [2:0]      issue_tag;
  logic            wb_valid;
  logic [2:0]      wb_tag;
  logic [XLEN-1:0] wb_data;
  logic [2:0]      qry1_tag;
  logic [2:0]      qry2_tag;
  logic            qry1_ready;
  logic            qry2_ready;
  logic [XLEN-1:0] qry1_value;
  logic [XLEN-1:0] qry2_value;
  logic            commit;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_data;
  logic [2:0]      commit_tag;

  modport master (
    output pause, flush, issue_valid, issue_rd, wb_valid, wb_tag, wb_data,
           qry1_tag, qry2_tag,
    input  issue_ready, issue_tag, qry1_ready, qry2_ready, qry1_value,
           qry2_value, commit, commit_rd, commit_data, commit_tag
  );

  modport slave (
    input  pause, flush, issue_valid, issue_rd, wb_valid, wb_tag, wb_data,
           qry1_tag, qry2_tag,
    output issue_ready, issue_tag, qry1_ready, qry2_ready, qry1_value,
           qry2_value, commit, commit_rd, commit_data, commit_tag
  );
endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Seven-entry in-order retirement buffer. Entries carry tags 1..7; tag 0
//   means "no dependency" and is never allocated. Results arrive out of order
//   on the writeback bus and retire in program order, one per cycle.
//
//   Ports:
//     clk    : sole clock, state updates on posedge
//     rst_n  : asynchronous active-low reset
//     rob    : reorder_buffer_if.slave (issue, writeback, query, commit)
//
//   XLEN must match the XLEN of the connected interface instance.
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst_n,
  reorder_buffer_if.slave rob
);

  // Index 0 exists only so 3-bit tags index directly; it is never written.
  logic [7:0]      busy_q, busy_d;
  logic [7:0]      done_q, done_d;
  logic [4:0]      rd_q   [8];
  logic [4:0]      rd_d   [8];
  logic [XLEN-1:0] data_q [8];
  logic [XLEN-1:0] data_d [8];
  logic [2:0]      head_q, head_d;
  logic [2:0]      tail_q, tail_d;
  logic [2:0]      count_q, count_d;

  logic issue_fire;
  logic commit_fire;
  logic wb_fire;

  // Pointers cycle 1..7 and skip tag 0.
  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p == 3'd7) ? 3'd1 : p + 3'd1;
  endfunction

  assign rob.issue_tag   = tail_q;
  assign rob.issue_ready = (count_q != 3'd7) && !rob.pause && !rob.flush;

  assign issue_fire  = rob.issue_valid && rob.issue_ready;
  assign commit_fire = busy_q[head_q] && done_q[head_q] && !rob.pause && !rob.flush;
  assign wb_fire     = rob.wb_valid && (rob.wb_tag != 3'd0) && busy_q[rob.wb_tag] &&
                       !rob.pause;

  // Commit payload is forced to zero when not retiring so the register file
  // never sees a stale head entry.
  assign rob.commit      = commit_fire;
  assign rob.commit_rd   = commit_fire ? rd_q[head_q]   : 5'd0;
  assign rob.commit_data = commit_fire ? data_q[head_q] : '0;
  assign rob.commit_tag  = commit_fire ? head_q         : 3'd0;

  // Operand queries: a same-cycle broadcast wins over the stored value so a
  // dependent instruction can pick up a result the cycle it is produced.
  always_comb begin
    rob.qry1_ready = 1'b0;
    rob.qry1_value = '0;
    if (rob.qry1_tag != 3'd0) begin
      if (rob.wb_valid && (rob.wb_tag == rob.qry1_tag)) begin
        rob.qry1_ready = 1'b1;
        rob.qry1_value = rob.wb_data;
      end else if (busy_q[rob.qry1_tag] && done_q[rob.qry1_tag]) begin
        rob.qry1_ready = 1'b1;
        rob.qry1_value = data_q[rob.qry1_tag];
      end
    end
  end

  always_comb begin
    rob.qry2_ready = 1'b0;
    rob.qry2_value = '0;
    if (rob.qry2_tag != 3'd0) begin
      if (rob.wb_valid && (rob.wb_tag == rob.qry2_tag)) begin
        rob.qry2_ready = 1'b1;
        rob.qry2_value = rob.wb_data;
      end else if (busy_q[rob.qry2_tag] && done_q[rob.qry2_tag]) begin
        rob.qry2_ready = 1'b1;
        rob.qry2_value = data_q[rob.qry2_tag];
      end
    end
  end

  // Next state. Commit and issue never touch the same entry: commit needs a
  // busy head, issue needs a free tail, and head==tail only when empty/full.
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rob.flush && !rob.pause) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = 3'd1;
      tail_d  = 3'd1;
      count_d = 3'd0;
    end else begin
      if (wb_fire) begin
        done_d[rob.wb_tag] = 1'b1;
        data_d[rob.wb_tag] = rob.wb_data;
      end
      if (commit_fire) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = next_ptr(head_q);
      end
      if (issue_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        rd_d[tail_q]   = rob.issue_rd;
        tail_d         = next_ptr(tail_q);
      end
      if (issue_fire && !commit_fire) begin
        count_d = count_q + 3'd1;
      end else if (commit_fire && !issue_fire) begin
        count_d = count_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= 3'd1;
      tail_q  <= 3'd1;
      count_q <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Table-driven bench for reorder_buffer: each record holds one cycle of
//   inputs and the combinational outputs expected in that cycle. A hand-written
//   sequence covers asynchronous reset between clock edges.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            iv;
    logic [4:0]      ird;
    logic            wv;
    logic [2:0]      wtag;
    logic [XLEN-1:0] wdata;
    logic [2:0]      q1t;
    logic [2:0]      q2t;
    logic            ps;
    logic            fl;
  } vin_t;

  typedef struct packed {
    logic            ir;
    logic [2:0]      itag;
    logic            cm;
    logic [4:0]      crd;
    logic [XLEN-1:0] cdata;
    logic [2:0]      ctag;
    logic            q1r;
    logic [XLEN-1:0] q1v;
    logic            q2r;
    logic [XLEN-1:0] q2v;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  vec_t vecs[$];

  reorder_buffer_if #(.XLEN(XLEN)) bus ();

  reorder_buffer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rob   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic vin_t vi(input logic iv, input logic [4:0] ird, input logic wv,
                              input logic [2:0] wtag, input logic [XLEN-1:0] wdata,
                              input logic [2:0] q1t, input logic [2:0] q2t,
                              input logic ps, input logic fl);
    vin_t v;
    v = '{iv, ird, wv, wtag, wdata, q1t, q2t, ps, fl};
    return v;
  endfunction

  function automatic vout_t vo(input logic ir, input logic [2:0] itag, input logic cm,
                               input logic [4:0] crd, input logic [XLEN-1:0] cdata,
                               input logic [2:0] ctag, input logic q1r,
                               input logic [XLEN-1:0] q1v, input logic q2r,
                               input logic [XLEN-1:0] q2v);
    vout_t v;
    v = '{ir, itag, cm, crd, cdata, ctag, q1r, q1v, q2r, q2v};
    return v;
  endfunction

  function automatic vin_t idle_in();
    return vi(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vout_t quiet(input logic ir, input logic [2:0] itag);
    return vo(ir, itag, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(input vin_t i, input vout_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vin_t v);
    bus.issue_valid = v.iv;
    bus.issue_rd    = v.ird;
    bus.wb_valid    = v.wv;
    bus.wb_tag      = v.wtag;
    bus.wb_data     = v.wdata;
    bus.qry1_tag    = v.q1t;
    bus.qry2_tag    = v.q2t;
    bus.pause       = v.ps;
    bus.flush       = v.fl;
  endtask

  function automatic vout_t sample();
    return vo(bus.issue_ready, bus.issue_tag, bus.commit, bus.commit_rd,
              bus.commit_data, bus.commit_tag, bus.qry1_ready, bus.qry1_value,
              bus.qry2_ready, bus.qry2_value);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input vout_t got, input vout_t exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got ir=%b itag=%0d cm=%b crd=%0d cdata=%h ctag=%0d q1=%b/%h q2=%b/%h | need ir=%b itag=%0d cm=%b crd=%0d cdata=%h ctag=%0d q1=%b/%h q2=%b/%h",
               name, got.ir, got.itag, got.cm, got.crd, got.cdata, got.ctag,
               got.q1r, got.q1v, got.q2r, got.q2v,
               exp.ir, exp.itag, exp.cm, exp.crd, exp.cdata, exp.ctag,
               exp.q1r, exp.q1v, exp.q2r, exp.q2v);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    drive(idle_in());

    // Reset state while reset is held.
    @(negedge clk);
    #2;
    check("reset_hold", sample(), quiet(1, 1));
    @(negedge clk);
    rst_n = 1'b1;

    // Out-of-order writeback, in-order commit.
    add(idle_in(),                              quiet(1, 1));
    add(vi(1, 5, 0, 0, 0, 0, 0, 0, 0),          quiet(1, 1));
    add(vi(1, 6, 0, 0, 0, 0, 0, 0, 0),          quiet(1, 2));
    add(vi(0, 0, 1, 2, 32'hB, 2, 1, 0, 0),      vo(1, 3, 0, 0, 0, 0, 1, 32'hB, 0, 0));
    add(vi(0, 0, 1, 1, 32'hA, 2, 1, 0, 0),      vo(1, 3, 0, 0, 0, 0, 1, 32'hB, 1, 32'hA));
    add(idle_in(),                              vo(1, 3, 1, 5, 32'hA, 1, 0, 0, 0, 0));
    add(idle_in(),                              vo(1, 3, 1, 6, 32'hB, 2, 0, 0, 0, 0));
    add(idle_in(),                              quiet(1, 3));
    // Bypass on same-cycle broadcast; tag 0 never ready.
    add(vi(0, 0, 1, 3, 32'h55, 3, 0, 0, 0),     vo(1, 3, 0, 0, 0, 0, 1, 32'h55, 0, 0));
    add(vi(0, 0, 1, 0, 32'h77, 0, 0, 0, 0),     quiet(1, 3));
    // Flush on an empty buffer realigns pointers to 1.
    add(vi(0, 0, 0, 0, 0, 0, 0, 0, 1),          quiet(0, 3));
    // Fill all seven entries.
    for (int k = 1; k <= 7; k++) begin
      add(vi(1, 5'(k), 0, 0, 0, 0, 0, 0, 0),    quiet(1, 3'(k)));
    end
    add(vi(1, 9, 0, 0, 0, 0, 0, 0, 0),          quiet(0, 1));
    add(vi(1, 9, 1, 1, 32'h11, 1, 0, 0, 0),     vo(0, 1, 0, 0, 0, 0, 1, 32'h11, 0, 0));
    // Full buffer commits but may not issue in the same cycle.
    add(vi(1, 9, 0, 0, 0, 0, 0, 0, 0),          vo(0, 1, 1, 1, 32'h11, 1, 0, 0, 0, 0));
    // Tail wraps to tag 1.
    add(vi(1, 10, 0, 0, 0, 0, 0, 0, 0),         quiet(1, 1));
    add(idle_in(),                              quiet(0, 2));
    // Pause blocks commit and writeback storage.
    add(vi(0, 0, 1, 2, 32'h22, 0, 0, 0, 0),     quiet(0, 2));
    add(vi(0, 0, 1, 3, 32'h33, 3, 0, 1, 0),     vo(0, 2, 0, 0, 0, 0, 1, 32'h33, 0, 0));
    add(vi(0, 0, 0, 0, 0, 3, 0, 1, 0),          quiet(0, 2));
    add(idle_in(),                              vo(0, 2, 1, 2, 32'h22, 2, 0, 0, 0, 0));
    add(idle_in(),                              quiet(1, 2));
    // Flush with busy entries; late writeback ignored.
    add(vi(0, 0, 1, 4, 32'h44, 0, 0, 0, 0),     quiet(1, 2));
    add(vi(0, 0, 0, 0, 0, 4, 0, 0, 1),          vo(0, 2, 0, 0, 0, 0, 1, 32'h44, 0, 0));
    add(vi(0, 0, 1, 2, 32'hBAD, 4, 0, 0, 0),    quiet(1, 1));
    add(vi(0, 0, 0, 0, 0, 2, 0, 0, 0),          quiet(1, 1));
    // rd = 0 still commits.
    add(vi(1, 0, 0, 0, 0, 0, 0, 0, 0),          quiet(1, 1));
    add(vi(0, 0, 1, 1, 32'h5A, 0, 0, 0, 0),     quiet(1, 2));
    add(idle_in(),                              vo(1, 2, 1, 0, 32'h5A, 1, 0, 0, 0, 0));
    add(idle_in(),                              quiet(1, 2));
    // Flush beats a ready commit.
    add(vi(1, 3, 0, 0, 0, 0, 0, 0, 0),          quiet(1, 2));
    add(vi(0, 0, 1, 2, 32'h66, 0, 0, 0, 0),     quiet(1, 3));
    add(vi(0, 0, 0, 0, 0, 0, 0, 0, 1),          quiet(0, 3));
    add(idle_in(),                              quiet(1, 1));

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      drive(vecs[n].i);
      #2;
      check($sformatf("vec%0d", n), sample(), vecs[n].o);
    end

    // Asynchronous reset between edges with a retiring head.
    @(negedge clk); drive(vi(1, 12, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(vi(1, 13, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(vi(0, 0, 1, 1, 32'hC1, 0, 0, 0, 0));
    @(negedge clk); drive(vi(0, 0, 1, 2, 32'hC2, 0, 0, 0, 0));
    @(negedge clk); drive(idle_in());
    #2;
    check("pre_reset_commit", sample(), vo(1, 3, 1, 13, 32'hC2, 2, 0, 0, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", sample(), quiet(1, 1));
    @(negedge clk);
    #2;
    check("reset_held", sample(), quiet(1, 1));
    rst_n = 1'b1;
    @(negedge clk);
    drive(vi(0, 0, 0, 0, 0, 2, 1, 0, 0));
    #2;
    check("after_reset", sample(), quiet(1, 1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, data width of results.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port pause, input, 1, pipeline stall; freezes all state.
REQ-005 The block SHALL have port flush, input, 1, synchronous discard of all entries.
REQ-006 The block SHALL have port issue_valid, input, 1, decoder requests a new entry.
REQ-007 The block SHALL have port issue_rd, input, 5, destination register of the issuing instruction.
REQ-008 The block SHALL have port issue_ready, output, 1, an entry can be allocated this cycle.
REQ-009 The block SHALL have port issue_tag, output, 3, tag of the next entry (drives register-file dependency_num).
REQ-010 The block SHALL have port wb_valid, input, 1, result broadcast strobe.
REQ-011 The block SHALL have port wb_tag, input, 3, tag of the broadcast result.
REQ-012 The block SHALL have port wb_data, input, XLEN, broadcast result value.
REQ-013 The block SHALL have ports qry1_tag and qry2_tag, input, 3 each, operand tags from register-file query1/query2.
REQ-014 The block SHALL have ports qry1_ready and qry2_ready, output, 1 each, the queried result is available.
REQ-015 The block SHALL have ports qry1_value and qry2_value, output, XLEN each, the queried result value.
REQ-016 The block SHALL have port commit, output, 1, retire strobe to the register file.
REQ-017 The block SHALL have port commit_rd, output, 5, register written (register-file reg_num).
REQ-018 The block SHALL have port commit_data, output, XLEN, value written (register-file data_in).
REQ-019 The block SHALL have port commit_tag, output, 3, tag retired (register-file num_in).

Function
REQ-020 Storage SHALL be 7 entries with tags 1..7; tag 0 SHALL mean "no dependency" and never be allocated.
REQ-021 Each entry SHALL hold busy, done, rd[4:0], data[XLEN-1:0].
REQ-022 Head and tail pointers SHALL be 3-bit, advancing 1,2,...,7,1 (7 wraps to 1); count SHALL range 0..7.
REQ-023 issue_tag SHALL equal tail combinationally; issue_ready SHALL be (count<7) && !pause && !flush.
REQ-024 Issue fires on posedge when issue_valid && issue_ready: entry[tail] busy=1, done=0, rd=issue_rd; tail advances.
REQ-025 Writeback with wb_valid, wb_tag!=0 and entry[wb_tag].busy SHALL set done=1 and data=wb_data at posedge; otherwise ignored.
REQ-026 commit SHALL be combinational: entry[head].busy && entry[head].done && !pause && !flush; commit_rd/commit_data/commit_tag from entry[head].
REQ-027 When commit is high, at posedge entry[head].busy SHALL clear and head SHALL advance; at most one retire per cycle.
REQ-028 Entries with rd=0 SHALL still commit (register file ignores x0).
REQ-029 count SHALL increment on issue only, decrement on commit only, unchanged on both; a full buffer SHALL not accept issue in the same cycle it commits.
REQ-030 Result written at edge N to the head entry SHALL commit in cycle N+1 (one-cycle minimum writeback-to-commit latency).
REQ-031 qryN_ready SHALL be 1 when qryN_tag!=0 and either entry[qryN_tag].busy && done, or wb_valid && wb_tag==qryN_tag (same-cycle bypass, value=wb_data); else ready=0, value=0.
REQ-032 pause high SHALL block issue, writeback, commit and flush state updates; producers hold inputs.
REQ-033 flush SHALL take priority over issue, writeback and commit: at posedge all busy/done=0, head=tail=1, count=0.

Reset
REQ-034 rst_n low SHALL asynchronously clear all busy/done/rd/data, set head=tail=1, count=0.
REQ-035 During and after reset until first issue: commit=0, commit_rd=0, commit_data=0, commit_tag=0, qry ready/value=0, issue_tag=1, issue_ready=1 (pause low).
REQ-036 Reset asserted mid-operation SHALL discard all in-flight entries without a commit pulse.

Verification
REQ-037 Issue rd=5, rd=6 -> tags 1,2; wb tag 2 data 0xB then tag 1 data 0xA -> commit tag1 rd5 0xA, next cycle tag2 rd6 0xB.
REQ-038 Issue 7 entries -> issue_ready=0, issue_tag=1; wb tag1, commit, then issue -> allocates tag 1 (wrap).
REQ-039 Query tag 3 with wb_valid tag 3 data 0x55 same cycle -> qry1_ready=1, qry1_value=0x55; qry tag 0 -> ready 0.
REQ-040 Three entries busy, flush -> count 0, issue_tag=1, no commit pulse; late wb tag 2 -> ignored.
REQ-041 Head done with pause high -> commit=0, head unchanged; pause low -> commit next cycle.
REQ-042 rst_n low asynchronously between edges with entries done -> commit drops to 0 immediately, issue_tag=1.
